// File: rtl/proc_fetch_seq.sv
// Instruction-fetch sequencer: loads reset/IRQ vectors, fetches opcode and
// operand bytes over a byte-wide wait-stated memory port, issues to execute.
module proc_fetch_seq #(
    parameter logic [15:0] RESET_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC      = 16'hFFFE,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_rdata,
    input  logic [1:0]  op_len,
    output logic [7:0]  ir,
    output logic [15:0] operand,
    output logic [15:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        irq,
    input  logic        irq_mask,
    output logic        irq_taken,
    output logic [15:0] irq_ret_pc,
    output logic        fault
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [3:0] {
        S_RESET,
        S_VEC_LO,
        S_VEC_HI,
        S_FETCH,
        S_DECODE,
        S_OPER_LO,
        S_OPER_HI,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic [ADDR_W-1:0]   vec, vec_d;
    logic [1:0]          len, len_d;
    logic [CNT_W-1:0]    wcnt, wcnt_d;
    logic [ADDR_W-1:0]   mem_addr_d, operand_d, pc_out_d, irq_ret_pc_d;
    logic [7:0]          ir_d;
    logic                mem_req_d, instr_valid_d, irq_taken_d, fault_d;
    logic                rd_state, rd_ack;

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_RESET;
            pc          <= '0;
            vec         <= RESET_VEC;
            len         <= '0;
            wcnt        <= '0;
            mem_addr    <= RESET_VEC;
            mem_req     <= 1'b0;
            ir          <= '0;
            operand     <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            irq_taken   <= 1'b0;
            irq_ret_pc  <= '0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            vec         <= vec_d;
            len         <= len_d;
            wcnt        <= wcnt_d;
            mem_addr    <= mem_addr_d;
            mem_req     <= mem_req_d;
            ir          <= ir_d;
            operand     <= operand_d;
            pc_out      <= pc_out_d;
            instr_valid <= instr_valid_d;
            irq_taken   <= irq_taken_d;
            irq_ret_pc  <= irq_ret_pc_d;
            fault       <= fault_d;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        vec_d        = vec;
        len_d        = len;
        wcnt_d       = '0;
        ir_d         = ir;
        operand_d    = operand;
        pc_out_d     = pc_out;
        irq_ret_pc_d = irq_ret_pc;
        irq_taken_d  = 1'b0;
        mem_addr_d   = mem_addr;
        mem_req_d    = 1'b0;

        rd_state = (state == S_VEC_LO) || (state == S_VEC_HI) || (state == S_FETCH) ||
                   (state == S_OPER_LO) || (state == S_OPER_HI);
        rd_ack   = rd_state && mem_rdy;

        case (state)
            S_RESET: begin
                vec_d   = RESET_VEC;
                state_d = S_VEC_LO;
            end
            S_VEC_LO: if (rd_ack) begin
                pc_d[7:0] = mem_rdata;
                state_d   = S_VEC_HI;
            end
            S_VEC_HI: if (rd_ack) begin
                pc_d[15:8] = mem_rdata;
                state_d    = S_FETCH;
            end
            S_FETCH: if (rd_ack) begin
                ir_d      = mem_rdata;
                pc_out_d  = pc;
                pc_d      = pc + 16'd1;
                operand_d = '0;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                len_d = op_len;
                case (op_len)
                    2'd0:    state_d = S_ISSUE;
                    2'd3:    state_d = S_HALT;
                    default: state_d = S_OPER_LO;
                endcase
            end
            S_OPER_LO: if (rd_ack) begin
                operand_d[7:0] = mem_rdata;
                pc_d           = pc + 16'd1;
                state_d        = (len == 2'd2) ? S_OPER_HI : S_ISSUE;
            end
            S_OPER_HI: if (rd_ack) begin
                operand_d[15:8] = mem_rdata;
                pc_d            = pc + 16'd1;
                state_d         = S_ISSUE;
            end
            S_ISSUE: if (instr_ready) begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    state_d = S_FETCH;
                end else if (irq && !irq_mask) begin
                    irq_ret_pc_d = pc;
                    irq_taken_d  = 1'b1;
                    vec_d        = IRQ_VEC;
                    state_d      = S_VEC_LO;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase

        // Wait-state watchdog: counts consecutive stalled read cycles.
        if (WAIT_TIMEOUT != 0 && rd_state && !mem_rdy) begin
            wcnt_d = wcnt + CNT_W'(1);
            if (wcnt_d == CNT_W'(WAIT_TIMEOUT)) begin
                state_d = S_HALT;
            end
        end

        fault_d       = fault || (state_d == S_HALT);
        instr_valid_d = (state_d == S_ISSUE);

        case (state_d)
            S_VEC_LO: begin
                mem_req_d  = 1'b1;
                mem_addr_d = vec_d;
            end
            S_VEC_HI: begin
                mem_req_d  = 1'b1;
                mem_addr_d = vec_d + 16'd1;
            end
            S_FETCH, S_OPER_LO, S_OPER_HI: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end
            default: mem_req_d = 1'b0;
        endcase
    end

endmodule
